// File: rtl/fsm_cycle_defs_pkg.sv
// Shared defaults and record layout for the cycle reporter.
// A record is packed as {seq, len} with the sequence number in the MSBs.
package fsm_cycle_defs;

  localparam int DEF_SEQ_W = 8;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_DEPTH = 4;

  localparam int REC_LEN_LSB = 0;

  function automatic int rec_seq_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int rec_width(input int seq_w, input int len_w);
    return seq_w + len_w;
  endfunction

endpackage

// File: rtl/fsm_cycle_reporter_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, so the slot being vacated is reused immediately.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Head is masked while empty so the output reads zero out of reset without clearing storage.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge Clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fsm_cycle_reporter.sv
// Turns each completion pulse into a {sequence, cycle length} record and buffers
// it for a valid/ready consumer; records arriving at a full FIFO are dropped.
module fsm_cycle_reporter
  import fsm_cycle_defs::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   Clk,
  input  logic                   rst,
  input  logic                   Cycle_done,
  output logic                   Rec_valid,
  input  logic                   Rec_ready,
  output logic [SEQ_W-1:0]       Rec_seq,
  output logic [LEN_W-1:0]       Rec_len,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow
);

  localparam int REC_W   = rec_width(SEQ_W, LEN_W);
  localparam int SEQ_LSB = rec_seq_lsb(LEN_W);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == LEN_MAX) ? v : v + LEN_W'(1);
  endfunction

  logic [LEN_W-1:0]       r_len_cnt;
  logic [SEQ_W-1:0]       r_seq_cnt;
  logic                   r_overflow;
  logic [REC_W-1:0]       w_rec;
  logic [REC_W-1:0]       w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic [$clog2(DEPTH):0] w_level;

  assign w_push = Cycle_done;
  assign w_pop  = ~w_empty & Rec_ready;
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_rec  = {r_seq_cnt, r_len_cnt};

  // The sequence number advances on every pulse, stored or dropped, so drops show as gaps.
  always_ff @(posedge Clk) begin
    if (rst) begin
      r_len_cnt  <= '0;
      r_seq_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_len_cnt <= Cycle_done ? LEN_W'(1) : sat_inc(r_len_cnt);
      if (Cycle_done) begin
        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign Rec_valid = ~w_empty;
  assign Rec_seq   = w_head[SEQ_LSB +: SEQ_W];
  assign Rec_len   = w_head[REC_LEN_LSB +: LEN_W];
  assign Level     = w_level;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_fsm_cycle_reporter.sv
// Directed bench for fsm_cycle_reporter: a vector table for the basic timing
// plus hand-written sequences for overflow, full-FIFO, saturation, wrap and reset.
module tb_fsm_cycle_reporter;

  localparam int SEQ_W = 8;
  localparam int LEN_W = 16;
  localparam int DEPTH = 4;

  logic             Clk = 1'b0;
  logic             rst = 1'b1;
  logic             Cycle_done = 1'b0;
  logic             Rec_ready = 1'b0;
  logic             Rec_valid;
  logic [SEQ_W-1:0] Rec_seq;
  logic [LEN_W-1:0] Rec_len;
  logic [2:0]       Level;
  logic             Overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  fsm_cycle_reporter #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .Cycle_done (Cycle_done),
    .Rec_valid  (Rec_valid),
    .Rec_ready  (Rec_ready),
    .Rec_seq    (Rec_seq),
    .Rec_len    (Rec_len),
    .Level      (Level),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic cd;
    logic rdy;
    logic ev;
    int   eseq;
    int   elen;
    int   elvl;
    logic eovf;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Cycle_done = 1'b0;
    Rec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse();
    Cycle_done = 1'b1;
    tick();
    Cycle_done = 1'b0;
  endtask

  int last_pulse;
  int exp_len;

  initial begin
    for (int i = 0; i < 14; i++) vecs[i] = '{cd:1'b0, rdy:1'b1, ev:1'b0, eseq:0, elen:0, elvl:0, eovf:1'b0};
    vecs[5].cd  = 1'b1;
    vecs[6]     = '{cd:1'b0, rdy:1'b1, ev:1'b1, eseq:0, elen:5, elvl:1, eovf:1'b0};
    vecs[12].cd = 1'b1;
    vecs[13]    = '{cd:1'b0, rdy:1'b1, ev:1'b1, eseq:1, elen:7, elvl:1, eovf:1'b0};

    // Table: pulses at cycles 5 and 12 with the consumer always ready
    do_reset();
    check("reset_seq", int'(Rec_seq), 0);
    check("reset_len", int'(Rec_len), 0);
    for (int i = 0; i < 14; i++) begin
      Cycle_done = vecs[i].cd;
      Rec_ready  = vecs[i].rdy;
      check($sformatf("t1_valid_c%0d", i), int'(Rec_valid), int'(vecs[i].ev));
      check($sformatf("t1_level_c%0d", i), int'(Level), vecs[i].elvl);
      check($sformatf("t1_ovf_c%0d", i), int'(Overflow), int'(vecs[i].eovf));
      if (vecs[i].ev) begin
        check($sformatf("t1_seq_c%0d", i), int'(Rec_seq), vecs[i].eseq);
        check($sformatf("t1_len_c%0d", i), int'(Rec_len), vecs[i].elen);
      end
      tick();
    end
    Cycle_done = 1'b0;

    // Overflow: six pulses spaced 3 cycles with no consumer
    do_reset();
    tick();
    for (int p = 0; p < 6; p++) begin
      last_pulse = cyc;
      pulse();
      check($sformatf("t2_level_p%0d", p), int'(Level), (p + 1 > 4) ? 4 : p + 1);
      check($sformatf("t2_ovf_p%0d", p), int'(Overflow), (p >= 4) ? 1 : 0);
      tick();
      tick();
    end
    Rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_valid_%0d", i), int'(Rec_valid), 1);
      check($sformatf("t2_seq_%0d", i), int'(Rec_seq), i);
      check($sformatf("t2_len_%0d", i), int'(Rec_len), (i == 0) ? 1 : 3);
      tick();
    end
    Rec_ready = 1'b0;
    check("t2_drained_valid", int'(Rec_valid), 0);
    check("t2_drained_level", int'(Level), 0);
    exp_len = cyc - last_pulse;
    pulse();
    check("t2_next_seq", int'(Rec_seq), 6);
    check("t2_next_len", int'(Rec_len), exp_len);
    check("t2_ovf_sticky", int'(Overflow), 1);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    Cycle_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    Cycle_done = 1'b0;
    check("t3_full_level", int'(Level), 4);
    check("t3_full_ovf", int'(Overflow), 0);
    Cycle_done = 1'b1;
    Rec_ready = 1'b1;
    tick();
    Cycle_done = 1'b0;
    Rec_ready = 1'b0;
    check("t3_pp_level", int'(Level), 4);
    check("t3_pp_ovf", int'(Overflow), 0);
    check("t3_pp_seq", int'(Rec_seq), 1);
    Rec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_drain_seq_%0d", i), int'(Rec_seq), i);
      check($sformatf("t3_drain_len_%0d", i), int'(Rec_len), 1);
      tick();
    end
    Rec_ready = 1'b0;
    check("t3_end_valid", int'(Rec_valid), 0);
    check("t3_end_ovf", int'(Overflow), 0);

    // Length saturation after a long idle stretch
    do_reset();
    Rec_ready = 1'b1;
    repeat (70000) tick();
    pulse();
    check("t4_sat_valid", int'(Rec_valid), 1);
    check("t4_sat_len", int'(Rec_len), 65535);
    check("t4_sat_seq", int'(Rec_seq), 0);
    tick();
    tick();
    pulse();
    check("t4_short_len", int'(Rec_len), 3);
    check("t4_short_seq", int'(Rec_seq), 1);
    Rec_ready = 1'b0;

    // Cycle_done held high, then continuous traffic across the sequence wrap
    do_reset();
    tick();
    tick();
    Cycle_done = 1'b1;
    repeat (3) tick();
    Cycle_done = 1'b0;
    check("t5_level", int'(Level), 3);
    Rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_seq_%0d", i), int'(Rec_seq), i);
      check($sformatf("t5_len_%0d", i), int'(Rec_len), (i == 0) ? 2 : 1);
      tick();
    end
    Cycle_done = 1'b1;
    for (int j = 0; j < 297; j++) begin
      if (j >= 1) begin
        check($sformatf("t5_wrap_seq_%0d", j), int'(Rec_seq), (3 + j - 1) % 256);
        check($sformatf("t5_wrap_lvl_%0d", j), int'(Level), 1);
      end
      if (j >= 2) check($sformatf("t5_wrap_len_%0d", j), int'(Rec_len), 1);
      tick();
    end
    Cycle_done = 1'b0;
    check("t5_last_seq", int'(Rec_seq), 299 % 256);
    check("t5_ovf", int'(Overflow), 0);
    tick();
    Rec_ready = 1'b0;

    // Reset mid-traffic with a coincident pulse
    do_reset();
    Cycle_done = 1'b1;
    repeat (5) tick();
    Cycle_done = 1'b0;
    check("t6_level_full", int'(Level), 4);
    check("t6_ovf_set", int'(Overflow), 1);
    Rec_ready = 1'b1;
    tick();
    Rec_ready = 1'b0;
    check("t6_level3", int'(Level), 3);
    check("t6_ovf_held", int'(Overflow), 1);
    rst = 1'b1;
    Cycle_done = 1'b1;
    Rec_ready = 1'b1;
    tick();
    rst = 1'b0;
    Cycle_done = 1'b0;
    Rec_ready = 1'b0;
    cyc = 0;
    check("t6_rst_level", int'(Level), 0);
    check("t6_rst_valid", int'(Rec_valid), 0);
    check("t6_rst_ovf", int'(Overflow), 0);
    check("t6_rst_seq", int'(Rec_seq), 0);
    check("t6_rst_len", int'(Rec_len), 0);
    repeat (4) tick();
    pulse();
    check("t6_post_valid", int'(Rec_valid), 1);
    check("t6_post_seq", int'(Rec_seq), 0);
    check("t6_post_len", int'(Rec_len), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
